// File: rtl/rcv_pkg.sv
// Shared types and limits for the UART receive block.
package rcv_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} rcv_state_t;

   localparam int unsigned MIN_BIT_PERIOD = 10;
   localparam int unsigned MIN_DATA_SIZE  = 5;
   localparam int unsigned MAX_DATA_SIZE  = 8;
   localparam int unsigned BIT_CNT_W      = 14;

endpackage

// File: rtl/rcv_if.sv
// Consumer-facing side of the receiver: received byte, status flags and read strobe.
interface rcv_if;

   logic       data_read;
   logic [7:0] rx_data;
   logic       data_ready;
   logic       overrun_error;
   logic       framing_error;

   modport master (
      input  data_read,
      output rx_data, data_ready, overrun_error, framing_error
   );

   modport slave (
      output data_read,
      input  rx_data, data_ready, overrun_error, framing_error
   );

endinterface

// File: rtl/rcv_timer.sv
// Bit-timing counter: pulses strobe every `period` enabled cycles, restarting after each strobe.
module rcv_timer
   import rcv_pkg::*;
(
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [BIT_CNT_W-1:0] period,
   output logic                 strobe
);

   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      strobe = 1'b0;
      cnt_d  = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == period - BIT_CNT_W'(1)) begin
            strobe = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/rcv_block.sv
// UART receiver: synchronizes serial_in, frames start/data/stop bits and holds the last good byte.
module rcv_block
   import rcv_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        serial_in,
   input  logic [3:0]  data_size,
   input  logic [13:0] bit_period,
   rcv_if.master       bus
);

   function automatic logic [3:0] clamp_size(input logic [3:0] size);
      if (size < 4'(MIN_DATA_SIZE) || size > 4'(MAX_DATA_SIZE)) return 4'(MAX_DATA_SIZE);
      return size;
   endfunction

   function automatic logic [13:0] clamp_period(input logic [13:0] period);
      if (period < 14'(MIN_BIT_PERIOD)) return 14'(MIN_BIT_PERIOD);
      return period;
   endfunction

   rcv_state_t              state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q, sync_d;
   logic                    sync_prev_q, sync_prev_d;
   logic                    sync_in;
   logic [3:0]              size_q, size_d;
   logic [13:0]             period_q, period_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [7:0]              shift_q, shift_d;
   logic [7:0]              rx_data_q, rx_data_d;
   logic                    data_ready_q, data_ready_d;
   logic                    overrun_q, overrun_d;
   logic                    framing_q, framing_d;
   logic                    strobe;
   logic [13:0]             timer_period;

   assign sync_in      = sync_q[SYNC_STAGES-1];
   assign sync_d       = {sync_q[SYNC_STAGES-2:0], serial_in};
   assign sync_prev_d  = sync_in;
   // The start bit is sampled half a period in so data bits land mid-bit.
   assign timer_period = (state_q == START) ? (period_q >> 1) : period_q;

   rcv_timer u_timer (
      .clk    (clk),
      .n_rst  (n_rst),
      .clear  (state_q == IDLE),
      .enable (state_q == START || state_q == DATA || state_q == STOP),
      .period (timer_period),
      .strobe (strobe)
   );

   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      period_d     = period_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      data_ready_d = data_ready_q;
      overrun_d    = overrun_q;
      framing_d    = framing_q;

      if (bus.data_read && data_ready_q) begin
         data_ready_d = 1'b0;
         overrun_d    = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (sync_prev_q && !sync_in) begin
               state_d   = START;
               size_d    = clamp_size(data_size);
               period_d  = clamp_period(bit_period);
               bit_cnt_d = '0;
            end
         end
         START: begin
            if (strobe) begin
               if (!sync_in) begin
                  state_d   = DATA;
                  framing_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (strobe) begin
               shift_d   = {sync_in, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_d == size_q) state_d = STOP;
            end
         end
         STOP: begin
            if (strobe) begin
               if (sync_in) begin
                  state_d = LOAD;
               end else begin
                  framing_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         LOAD: begin
            // Bits entered at the MSB end, so shift down to right-justify short frames.
            rx_data_d    = shift_q >> (4'(MAX_DATA_SIZE) - size_q);
            data_ready_d = 1'b1;
            if (data_ready_q) overrun_d = ~bus.data_read;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         sync_q       <= '1;
         sync_prev_q  <= 1'b1;
         size_q       <= '0;
         period_q     <= '0;
         bit_cnt_q    <= '0;
         rx_data_q    <= '0;
         data_ready_q <= 1'b0;
         overrun_q    <= 1'b0;
         framing_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         sync_prev_q  <= sync_prev_d;
         size_q       <= size_d;
         period_q     <= period_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_data_q    <= rx_data_d;
         data_ready_q <= data_ready_d;
         overrun_q    <= overrun_d;
         framing_q    <= framing_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign bus.rx_data       = rx_data_q;
   assign bus.data_ready    = data_ready_q;
   assign bus.overrun_error = overrun_q;
   assign bus.framing_error = framing_q;

endmodule

// File: doc/rcv_block.md
RCV_BLOCK -- requirements
Module: rcv_block

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, flops in serial_in synchronizer (legal 2..3).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: serial_in  input  1  asynchronous UART line, idle high.
REQ-005 SHALL have port: data_read  input  1  one-cycle pulse, consumer has taken rx_data.
REQ-006 SHALL have port: data_size  input  4  data bits per frame.
REQ-007 SHALL have port: bit_period  input  14  clk cycles per serial bit.
REQ-008 SHALL have port: rx_data  output  8  last good frame, right-justified, unused upper bits 0.
REQ-009 SHALL have port: data_ready  output  1  rx_data holds an unread frame.
REQ-010 SHALL have port: overrun_error  output  1  frame loaded while data_ready was 1.
REQ-011 SHALL have port: framing_error  output  1  last frame had stop bit 0.

Function
REQ-012 SHALL pass serial_in through SYNC_STAGES flops; all logic SHALL use the synchronized value (sync_in).
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP, LOAD.
REQ-014 IDLE->START on sync_in falling edge (previous 1, current 0); SHALL latch data_size and bit_period at this transition.
REQ-015 Latched data_size outside 5..8 SHALL be treated as 8; latched bit_period below 10 SHALL be treated as 10.
REQ-016 START: wait bit_period>>1 cycles, then sample; sample 0 -> DATA and clear framing_error; sample 1 -> IDLE (glitch), no output change.
REQ-017 DATA: sample sync_in every bit_period cycles after previous sample point, LSB first, into shift register; after data_size samples -> STOP.
REQ-018 STOP: sample bit_period cycles after last data sample; 1 -> LOAD; 0 -> set framing_error, discard frame, data_ready/rx_data unchanged, -> IDLE.
REQ-019 LOAD (one cycle): rx_data <= frame, data_ready <= 1; if data_ready already 1 and data_read not asserted same cycle, set overrun_error (new data overwrites old); -> IDLE.
REQ-020 data_ready SHALL assert exactly 2 clk after the stop-bit sample cycle (STOP->LOAD, LOAD->register).
REQ-021 data_read with data_ready=1 SHALL clear data_ready and overrun_error next cycle; data_read with data_ready=0 SHALL be ignored.
REQ-022 data_read coincident with LOAD: data_ready SHALL remain 1, overrun_error SHALL NOT set.
REQ-023 data_size/bit_period changes mid-frame SHALL NOT affect the frame in progress.
REQ-024 Bit counter SHALL be 14 bits, reload on each sample point, no wrap within a frame; data-bit counter 4 bits.
REQ-025 A falling edge during START/DATA/STOP SHALL NOT restart the frame.

Reset
REQ-026 On n_rst=0: FSM IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, data_ready 0, overrun_error 0, framing_error 0.
REQ-027 Reset mid-frame SHALL abort the frame; after release, reception SHALL begin only on a new falling edge.

Structure
REQ-028 Package rcv_pkg SHALL hold state enum rcv_state_t, MIN_BIT_PERIOD=10, MIN_DATA_SIZE=5, MAX_DATA_SIZE=8.
REQ-029 Bit-timing counter SHALL be sub-module rcv_timer (inputs clear, enable, period; output sample strobe).
REQ-030 Outputs SHALL be registered; connect directly to the APB slave's rx_data, data_ready, overrun_error, framing_error, data_read.

Verification
REQ-031 bit_period=10, data_size=8, frame 0x A5 with stop 1 -> rx_data=8'hA5, data_ready=1 2 clk after stop sample, errors 0.
REQ-032 bit_period=10, data_size=5, bits 10110 LSB-first, stop 1 -> rx_data=8'h0D, upper 3 bits 0.
REQ-033 Two good frames (0x11, 0x22) without data_read -> rx_data=8'h22, overrun_error=1; then data_read pulse -> data_ready=0, overrun_error=0.
REQ-034 Frame 0x3C with stop bit 0 -> framing_error=1, data_ready unchanged; next good frame START sample clears framing_error.
REQ-035 serial_in low 3 cycles with bit_period=20 -> returns IDLE, all outputs unchanged.
REQ-036 n_rst asserted at DATA bit 4 -> all outputs 0; after release, good frame 0x5A received correctly.
